// File: rtl/hazard_flush_ctrl_pkg.sv
// Shared encodings for the RV32I hazard / flush controller.
package hazard_flush_ctrl_pkg;

  localparam logic [1:0] PCSEL_SEQ   = 2'b00;
  localparam logic [1:0] PCSEL_TGT   = 2'b01;
  localparam logic [1:0] PCSEL_RECOV = 2'b10;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } hfc_state_e;

endpackage

// File: rtl/hazard_flush_ctrl_detect.sv
// Combinational load-use and branch/jump mispredict detection for the EX/ID slots.
module hazard_detect
  import hazard_flush_ctrl_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_branch,
  input  logic       i_ex_jump,
  input  logic       i_br_taken,
  input  logic       i_ex_bpred,
  input  logic       i_ex_bpred_valid,
  output logic       o_lu,
  output logic       o_mp,
  output logic [1:0] o_mp_pcsel
);

  logic w_pt;
  logic w_mp_tgt;
  logic w_mp_recov;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_pt       = i_ex_bpred & i_ex_bpred_valid;
  assign w_mp_tgt   = i_ex_valid & ~w_pt & (i_ex_jump | (i_ex_branch & i_br_taken));
  assign w_mp_recov = i_ex_valid & w_pt & i_ex_branch & ~i_br_taken;

  assign o_mp       = w_mp_tgt | w_mp_recov;
  assign o_mp_pcsel = w_mp_tgt ? PCSEL_TGT : (w_mp_recov ? PCSEL_RECOV : PCSEL_SEQ);

  assign w_rs1_hit = i_id_use_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_use_rs2 & (i_id_rs2 == i_ex_rd);
  assign o_lu      = i_ex_valid & i_ex_mem_read & (i_ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline stall/flush/PC-select controller; perf counters under HAZARD_PERF_CNT_EN.
//   state       | meaning
//   ST_RUN      | normal issue: mispredict > load-use > fetch miss
//   ST_REDIRECT | hold IF/ID flushed for bc valid fetches after a redirect
module hazard_flush_ctrl
  import hazard_flush_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_BUBBLES = 1
)(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IF_ID_Rs1,
  input  logic [4:0] IF_ID_Rs2,
  input  logic       IF_ID_UseRs1,
  input  logic       IF_ID_UseRs2,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] ID_EX_Rd,
  input  logic       ID_EX_Branch,
  input  logic       ID_EX_Jump,
  input  logic       BrTaken,
  input  logic       ID_EX_BPred,
  input  logic       ID_EX_BPredValid,
  input  logic       imem_valid,
  output logic       PC_Stall,
  output logic       IF_ID_Stall,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic [1:0] PCSel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);

  localparam logic [1:0] LP_BUBBLES = 2'(REDIRECT_BUBBLES);

  hfc_state_e r_state;
  hfc_state_e w_state_nxt;
  logic [1:0] r_bc;
  logic [1:0] w_bc_nxt;
  logic       r_ex_bubble;

  logic       w_lu;
  logic       w_mp;
  logic [1:0] w_mp_pcsel;

  logic       w_pc_stall;
  logic       w_if_id_stall;
  logic       w_if_id_flush;
  logic       w_id_ex_flush;
  logic [1:0] w_pcsel;

  hazard_detect u_detect (
    .i_ex_valid       (~r_ex_bubble),
    .i_id_rs1         (IF_ID_Rs1),
    .i_id_rs2         (IF_ID_Rs2),
    .i_id_use_rs1     (IF_ID_UseRs1),
    .i_id_use_rs2     (IF_ID_UseRs2),
    .i_ex_mem_read    (ID_EX_MemRead),
    .i_ex_rd          (ID_EX_Rd),
    .i_ex_branch      (ID_EX_Branch),
    .i_ex_jump        (ID_EX_Jump),
    .i_br_taken       (BrTaken),
    .i_ex_bpred       (ID_EX_BPred),
    .i_ex_bpred_valid (ID_EX_BPredValid),
    .o_lu             (w_lu),
    .o_mp             (w_mp),
    .o_mp_pcsel       (w_mp_pcsel)
  );

  always_comb begin
    w_pc_stall    = 1'b0;
    w_if_id_stall = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_pcsel       = PCSEL_SEQ;
    w_state_nxt   = r_state;
    w_bc_nxt      = r_bc;
    case (r_state)
      ST_RUN: begin
        if (w_mp) begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          w_pcsel       = w_mp_pcsel;
          if (LP_BUBBLES != 2'd0) begin
            w_state_nxt = ST_REDIRECT;
            w_bc_nxt    = LP_BUBBLES;
          end
        end else if (w_lu) begin
          w_pc_stall    = 1'b1;
          w_if_id_stall = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (!imem_valid) begin
          w_pc_stall    = 1'b1;
          w_if_id_flush = 1'b1;
        end
      end
      ST_REDIRECT: begin
        w_if_id_flush = 1'b1;
        w_pc_stall    = ~imem_valid;
        if (imem_valid) begin
          if (r_bc <= 2'd1) begin
            w_state_nxt = ST_RUN;
            w_bc_nxt    = 2'd0;
          end else begin
            w_bc_nxt = r_bc - 2'd1;
          end
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs are held at zero for the whole time reset is low, not just after an edge.
  assign PC_Stall    = reset & w_pc_stall;
  assign IF_ID_Stall = reset & w_if_id_stall;
  assign IF_ID_Flush = reset & w_if_id_flush;
  assign ID_EX_Flush = reset & w_id_ex_flush;
  assign PCSel       = reset ? w_pcsel : PCSEL_SEQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_bc        <= 2'd0;
      r_ex_bubble <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_bc        <= w_bc_nxt;
      r_ex_bubble <= ID_EX_Flush;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (PC_Stall && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if ((IF_ID_Flush || ID_EX_Flush) && (r_flush_cnt != 32'hFFFF_FFFF))
        r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign StallCnt = r_stall_cnt;
  assign FlushCnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Directed bench for hazard_flush_ctrl with REDIRECT_BUBBLES=1.
module tb_hazard_flush_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
  logic       IF_ID_UseRs1, IF_ID_UseRs2, ID_EX_MemRead;
  logic       ID_EX_Branch, ID_EX_Jump, BrTaken;
  logic       ID_EX_BPred, ID_EX_BPredValid, imem_valid;
  logic       PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush;
  logic [1:0] PCSel;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  // {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, PCSel}
  localparam logic [5:0] E_ZERO  = 6'b0000_00;
  localparam logic [5:0] E_LU    = 6'b1101_00;
  localparam logic [5:0] E_MPT   = 6'b0011_01;
  localparam logic [5:0] E_MPR   = 6'b0011_10;
  localparam logic [5:0] E_RD    = 6'b0010_00;
  localparam logic [5:0] E_MISS  = 6'b1010_00;

  logic [5:0] w_out;
  assign w_out = {PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, PCSel};

  hazard_flush_ctrl #(.REDIRECT_BUBBLES(1)) dut (
    .clk              (clk),
    .reset            (reset),
    .IF_ID_Rs1        (IF_ID_Rs1),
    .IF_ID_Rs2        (IF_ID_Rs2),
    .IF_ID_UseRs1     (IF_ID_UseRs1),
    .IF_ID_UseRs2     (IF_ID_UseRs2),
    .ID_EX_MemRead    (ID_EX_MemRead),
    .ID_EX_Rd         (ID_EX_Rd),
    .ID_EX_Branch     (ID_EX_Branch),
    .ID_EX_Jump       (ID_EX_Jump),
    .BrTaken          (BrTaken),
    .ID_EX_BPred      (ID_EX_BPred),
    .ID_EX_BPredValid (ID_EX_BPredValid),
    .imem_valid       (imem_valid),
    .PC_Stall         (PC_Stall),
    .IF_ID_Stall      (IF_ID_Stall),
    .IF_ID_Flush      (IF_ID_Flush),
    .ID_EX_Flush      (ID_EX_Flush),
    .PCSel            (PCSel)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt         (StallCnt),
    .FlushCnt         (FlushCnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    IF_ID_Rs1 = 5'd0; IF_ID_Rs2 = 5'd0; ID_EX_Rd = 5'd0;
    IF_ID_UseRs1 = 1'b0; IF_ID_UseRs2 = 1'b0; ID_EX_MemRead = 1'b0;
    ID_EX_Branch = 1'b0; ID_EX_Jump = 1'b0; BrTaken = 1'b0;
    ID_EX_BPred = 1'b0; ID_EX_BPredValid = 1'b0; imem_valid = 1'b1;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic ck(input string tag, input logic [5:0] exp);
    #2;
    chk(tag, {26'd0, w_out}, {26'd0, exp});
  endtask

  initial begin
    idle();
    imem_valid = 1'b0;
    ID_EX_Jump = 1'b1;
    ck("rst_outs", E_ZERO);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_stallcnt", StallCnt, 32'd0);
`endif
    nxt(); reset = 1'b1; idle();
    ck("post_rst", E_ZERO);
    nxt();

    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd5; IF_ID_Rs1 = 5'd5; IF_ID_UseRs1 = 1'b1;
    ck("lu_rs1", E_LU);
    nxt();
    ck("lu_no_restall", E_ZERO);
    nxt();
    ID_EX_Rd = 5'd0; IF_ID_Rs1 = 5'd0;
    ck("lu_rd0", E_ZERO);
    nxt();
    ID_EX_Rd = 5'd7; IF_ID_Rs1 = 5'd7; IF_ID_UseRs1 = 1'b0;
    ck("lu_unused_src", E_ZERO);
    nxt();
    IF_ID_Rs1 = 5'd0; IF_ID_Rs2 = 5'd7; IF_ID_UseRs2 = 1'b1;
    ck("lu_rs2", E_LU);
    nxt(); idle();
    ck("bubble_idle", E_ZERO);
    nxt();

    ID_EX_Branch = 1'b1; BrTaken = 1'b1;
    ck("br_taken_nopred", E_MPT);
    nxt();
    ck("redirect_1", E_RD);
    nxt(); idle();
    ck("redirect_done", E_ZERO);
    nxt();

    ID_EX_Jump = 1'b1;
    ck("jal_nopred", E_MPT);
    nxt(); idle(); imem_valid = 1'b0;
    ck("redirect_miss", E_MISS);
    nxt(); imem_valid = 1'b1;
    ck("redirect_hit", E_RD);
    nxt();
    ck("run_again", E_ZERO);
    nxt();

    ID_EX_Branch = 1'b1; BrTaken = 1'b0; ID_EX_BPred = 1'b1; ID_EX_BPredValid = 1'b1;
    ck("br_recov", E_MPR);
    nxt(); idle();
    ck("recov_redirect", E_RD);
    nxt();
    ID_EX_Branch = 1'b1; BrTaken = 1'b1; ID_EX_BPred = 1'b1; ID_EX_BPredValid = 1'b1;
    ck("br_pt_correct", E_ZERO);
    nxt(); idle();
    ID_EX_Jump = 1'b1; ID_EX_BPred = 1'b1; ID_EX_BPredValid = 1'b1;
    ck("jal_pt", E_ZERO);
    nxt(); idle();
    ID_EX_Branch = 1'b1; BrTaken = 1'b0; ID_EX_BPred = 1'b1;
    ck("br_nt_predinvalid", E_ZERO);
    nxt(); idle();

    ID_EX_Jump = 1'b1; ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd5;
    IF_ID_Rs1 = 5'd5; IF_ID_UseRs1 = 1'b1; imem_valid = 1'b0;
    ck("mp_over_lu", E_MPT);
    nxt(); idle();
    ck("mp_over_lu_redir", E_RD);
    nxt();
    ck("mp_over_lu_run", E_ZERO);
    nxt();

    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd9; IF_ID_Rs2 = 5'd9; IF_ID_UseRs2 = 1'b1;
    ck("lu_before_bubble", E_LU);
    nxt(); idle(); ID_EX_Jump = 1'b1;
    ck("bubble_jump", E_ZERO);
    nxt(); idle();
    ck("bubble_jump_after", E_ZERO);

    #1 reset = 1'b0;
    #1 reset = 1'b1;
    nxt();
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ck($sformatf("miss_%0d", i), E_MISS);
      nxt();
    end
    imem_valid = 1'b1;
    ck("miss_done", E_ZERO);
`ifdef HAZARD_PERF_CNT_EN
    chk("stallcnt_3", StallCnt, 32'd3);
    chk("flushcnt_3", FlushCnt, 32'd3);
`endif
    nxt();

    ID_EX_Jump = 1'b1;
    ck("jal_before_rst", E_MPT);
    nxt(); idle();
    ck("in_redirect", E_RD);
    reset = 1'b0;
    ck("rst_in_redirect", E_ZERO);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_stallcnt_0", StallCnt, 32'd0);
    chk("rst_flushcnt_0", FlushCnt, 32'd0);
`endif
    #2 reset = 1'b1;
    nxt();
    ck("run_after_rst", E_ZERO);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_flush_ctrl.md
# hazard_flush_ctrl

- Generates every stall, flush and PC-select control for the RV32I 5-stage pipeline registers.
- Detects load-use hazards in ID, resolves branch/jump prediction outcomes in EX, and absorbs instruction-memory latency after a redirect and on fetch misses.
- Sits beside the IF/ID and ID/EX pipeline registers and drives their Stall/Flush inputs and the PC mux select.

## Interface
- REDIRECT_BUBBLES, 1: extra cycles, range 0..3, during which IF_ID_Flush stays high after a redirect, covering synchronous imem latency.
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- IF_ID_Rs1, IF_ID_Rs2  in  5 each  source registers of the instruction in ID
- IF_ID_UseRs1, IF_ID_UseRs2  in  1 each  the ID instruction actually reads that source
- ID_EX_MemRead  in  1  EX instruction is a load
- ID_EX_Rd  in  5  EX destination register
- ID_EX_Branch, ID_EX_Jump  in  1 each  EX instruction is a conditional branch / a JAL or JALR
- BrTaken  in  1  branch condition result in EX
- ID_EX_BPred, ID_EX_BPredValid  in  1 each  prediction carried with the EX instruction
- imem_valid  in  1  the fetched instruction this cycle is valid
- PC_Stall  out  1  hold PC
- IF_ID_Stall  out  1  hold IF/ID
- IF_ID_Flush  out  1  load NOP (0x00000013) into IF/ID
- ID_EX_Flush  out  1  load bubble into ID/EX
- PCSel  out  2  PC source:
  - 00: sequential or predicted
  - 01: EX-computed target
  - 10: ID_EX_PC+4 recovery
- StallCnt, FlushCnt  out  32 each  performance counters; present only with HAZARD_PERF_CNT_EN

## Operation
- Internal flag ex_bubble is set when ID_EX_Flush was asserted in the previous cycle. While it is set, ID_EX_MemRead, ID_EX_Branch and ID_EX_Jump are ignored, because ID/EX passes Jump/Branch through on flush.
- Predicted-taken: pt = ID_EX_BPred & ID_EX_BPredValid.
- Mispredict, mp: EX slot valid and one of:
  - Jump & !pt, giving PCSel=01
  - Branch & BrTaken & !pt, giving PCSel=01
  - Branch & !BrTaken & pt, giving PCSel=10
- Load-use hazard, lu: EX slot valid & ID_EX_MemRead & ID_EX_Rd!=0, and (UseRs1 & Rs1==Rd, or UseRs2 & Rs2==Rd).
- The FSM has two states, RUN and REDIRECT, plus a 2-bit bubble counter bc.
- RUN, evaluated in priority order:
  - mp: IF_ID_Flush=1, ID_EX_Flush=1, PCSel as above. If REDIRECT_BUBBLES>0, go to REDIRECT with bc=REDIRECT_BUBBLES.
  - else lu: PC_Stall=1, IF_ID_Stall=1, ID_EX_Flush=1.
  - else !imem_valid: PC_Stall=1, IF_ID_Flush=1.
  - else all outputs 0, PCSel=00.
- REDIRECT:
  - Outputs: IF_ID_Flush=1, PC_Stall=!imem_valid; lu evaluation suppressed.
  - On each cycle with imem_valid=1, bc decrements; at bc==1 return to RUN.
  - mp cannot occur here, because the EX slot holds a bubble or a NOP.
- Simultaneous events: mp overrides lu and a fetch miss in the same cycle. Only one PCSel value is driven per cycle.
- Counters, when compiled in:
  - StallCnt increments on any cycle with PC_Stall=1.
  - FlushCnt increments on any cycle with IF_ID_Flush=1 or ID_EX_Flush=1.
  - Both saturate at 0xFFFFFFFF.

## Timing
- While reset is low: state=RUN, bc=0, ex_bubble=1, counters=0, and every output is forced to 0 (PCSel=00).
- Detection outputs (lu, mp, fetch miss) are combinational and take effect at the next rising clk edge.
- Zero-cycle decision latency; FSM and ex_bubble are registered.
- Load-use costs exactly 1 stall cycle. The following cycle sees ex_bubble=1, so there is no re-stall.
- Mispredict costs 2+REDIRECT_BUBBLES cycles of wrong-path loss, plus any cycles with imem_valid=0.
- Reset asserted mid-REDIRECT returns to RUN immediately, asynchronously.

## Configuration
- HAZARD_PERF_CNT_EN defined: StallCnt/FlushCnt ports and their registers exist.
- HAZARD_PERF_CNT_EN undefined: ports and logic are absent, and the control behaviour is identical.

## Structure
- Shared package holds:
  - PCSel encodings PCSEL_SEQ=2'b00, PCSEL_TGT=2'b01, PCSEL_RECOV=2'b10
  - FSM state enum
  - NOP constant 32'h00000013
- One sub-module, hazard_detect: the purely combinational lu and mp equations. The FSM, ex_bubble and counters stay at top level.

## Test plan
- Load x5, EX Rd=5 MemRead=1; ID Rs1=5 UseRs1=1 -> PC_Stall=IF_ID_Stall=ID_EX_Flush=1 for 1 cycle, then all 0. Same with Rd=0 -> no stall.
- Branch in EX, BrTaken=1, BPredValid=0 -> PCSel=01, both flushes high. With REDIRECT_BUBBLES=1, IF_ID_Flush stays high 1 more cycle, then RUN.
- Branch BrTaken=0, BPred=1 BPredValid=1 -> PCSel=10 and a flush. BrTaken=1 with pt=1 -> no flush, PCSel=00.
- mp and lu in the same cycle -> PCSel set, ID_EX_Flush=1, PC_Stall=0.
- ex_bubble=1 with ID_EX_Jump=1 passed through the flush -> no redirect.
- imem_valid=0 for 3 cycles in RUN -> PC_Stall=IF_ID_Flush=1 for 3 cycles; with the macro defined, StallCnt=3 and FlushCnt=3. Reset pulsed in REDIRECT -> outputs 0 and counters 0.
